// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes,
// control-bundle bit layout and forwarding-select encodings.
package pipe_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  // Bundle is {regwrite,memtoreg,memwrite,aluop,alusrc,regdst,branch,jump}, LSB first below
  localparam int CTRL_JUMP       = 0;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_REGDST     = 2;
  localparam int CTRL_ALUSRC     = 3;
  localparam int CTRL_ALUOP      = 4;
  localparam int CTRL_FIXED_BITS = 7;

  function automatic int ctrl_width(input int aluopw);
    return CTRL_FIXED_BITS + aluopw;
  endfunction

  function automatic int ctrl_memwrite(input int aluopw);
    return CTRL_ALUOP + aluopw;
  endfunction

  function automatic int ctrl_memtoreg(input int aluopw);
    return CTRL_ALUOP + aluopw + 1;
  endfunction

  function automatic int ctrl_regwrite(input int aluopw);
    return CTRL_ALUOP + aluopw + 2;
  endfunction

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle in, stall/flush/forward and per-stage controls out.
// The master is the datapath/decoder; the slave is the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int REGW   = 5,
  parameter int ALUOPW = 4,
  parameter int CNTW   = 16
);
  logic [6+ALUOPW:0] ctrld;
  logic [REGW-1:0]   rsd, rtd, rdd;
  logic              eqd;

  logic              stallf, stalld, flushd, flushe;
  logic              pcsrcd, jumpsel;
  logic              forwardad, forwardbd;
  logic [1:0]        forwardae, forwardbe;

  logic              regwritee, memtorege, memwritee, alusrce, regdste;
  logic [ALUOPW-1:0] aluope;
  logic [REGW-1:0]   writerege;
  logic              regwritem, memtoregm, memwritem;
  logic [REGW-1:0]   writeregm;
  logic              regwritew, memtoregw;
  logic [REGW-1:0]   writeregw;
  logic [CNTW-1:0]   stallcnt;

  modport master (
    output ctrld, rsd, rtd, rdd, eqd,
    input  stallf, stalld, flushd, flushe, pcsrcd, jumpsel,
    input  forwardad, forwardbd, forwardae, forwardbe,
    input  regwritee, memtorege, memwritee, alusrce, regdste, aluope, writerege,
    input  regwritem, memtoregm, memwritem, writeregm,
    input  regwritew, memtoregw, writeregw, stallcnt
  );

  modport slave (
    input  ctrld, rsd, rtd, rdd, eqd,
    output stallf, stalld, flushd, flushe, pcsrcd, jumpsel,
    output forwardad, forwardbd, forwardae, forwardbe,
    output regwritee, memtorege, memwritee, alusrce, regdste, aluope, writerege,
    output regwritem, memtoregm, memwritem, writeregm,
    output regwritew, memtoregw, writeregw, stallcnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Forwarding compare logic: ALU operand selects in E, comparator operand
// selects in D. Destination $0 is never a forwarding source.
module pipe_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rsd,
  input  logic [REGW-1:0] rtd,
  input  logic [REGW-1:0] rse,
  input  logic [REGW-1:0] rte,
  input  logic [REGW-1:0] writeregm,
  input  logic [REGW-1:0] writeregw,
  input  logic            regwritem,
  input  logic            regwritew,
  output logic [1:0]      forwardae,
  output logic [1:0]      forwardbe,
  output logic            forwardad,
  output logic            forwardbd
);

  logic memvalid, wbvalid;

  assign memvalid = regwritem && (writeregm != '0);
  assign wbvalid  = regwritew && (writeregw != '0);

  // M stage wins over W since it holds the younger result
  always_comb begin
    forwardae = FWD_RF;
    forwardbe = FWD_RF;
    if (memvalid && (writeregm == rse))     forwardae = FWD_MEM;
    else if (wbvalid && (writeregw == rse)) forwardae = FWD_WB;
    if (memvalid && (writeregm == rte))     forwardbe = FWD_MEM;
    else if (wbvalid && (writeregw == rte)) forwardbe = FWD_WB;
  end

  assign forwardad = (rsd != '0) && regwritem && (writeregm == rsd);
  assign forwardbd = (rtd != '0) && regwritem && (writeregm == rtd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control sequencer: carries D-stage controls through E/M/W,
// detects load-use and branch hazards, resolves redirects, counts stalls.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REGW   = 5,
  parameter int ALUOPW = 4,
  parameter int CNTW   = 16
) (
  input logic              clk,
  input logic              rstn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CW     = ctrl_width(ALUOPW);
  localparam int MEMWR  = ctrl_memwrite(ALUOPW);
  localparam int MEMTOR = ctrl_memtoreg(ALUOPW);
  localparam int REGWR  = ctrl_regwrite(ALUOPW);

  logic [CW-1:0]     ctrld;
  logic              jumpd, branchd;
  logic              lwstall, branchstall, stall, pcsrc, jsel;

  logic              regwritee, memtorege, memwritee, alusrce, regdste;
  logic [ALUOPW-1:0] aluope;
  logic [REGW-1:0]   rse, rte, rde, writerege;
  logic              regwritem, memtoregm, memwritem;
  logic [REGW-1:0]   writeregm;
  logic              regwritew, memtoregw;
  logic [REGW-1:0]   writeregw;
  logic [CNTW-1:0]   stallcnt;

  assign ctrld   = bus.ctrld;
  assign jumpd   = ctrld[CTRL_JUMP];
  assign branchd = ctrld[CTRL_BRANCH];

  // A stalled cycle loads a bubble into E while D is held
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regwritee <= 1'b0;
      memtorege <= 1'b0;
      memwritee <= 1'b0;
      alusrce   <= 1'b0;
      regdste   <= 1'b0;
      aluope    <= '0;
      rse       <= '0;
      rte       <= '0;
      rde       <= '0;
    end else if (stall) begin
      regwritee <= 1'b0;
      memtorege <= 1'b0;
      memwritee <= 1'b0;
      alusrce   <= 1'b0;
      regdste   <= 1'b0;
      aluope    <= '0;
      rse       <= '0;
      rte       <= '0;
      rde       <= '0;
    end else begin
      regwritee <= ctrld[REGWR];
      memtorege <= ctrld[MEMTOR];
      memwritee <= ctrld[MEMWR];
      alusrce   <= ctrld[CTRL_ALUSRC];
      regdste   <= ctrld[CTRL_REGDST];
      aluope    <= ctrld[CTRL_ALUOP +: ALUOPW];
      rse       <= bus.rsd;
      rte       <= bus.rtd;
      rde       <= bus.rdd;
    end
  end

  assign writerege = regdste ? rde : rte;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regwritem <= 1'b0;
      memtoregm <= 1'b0;
      memwritem <= 1'b0;
      writeregm <= '0;
      regwritew <= 1'b0;
      memtoregw <= 1'b0;
      writeregw <= '0;
    end else begin
      regwritem <= regwritee;
      memtoregm <= memtorege;
      memwritem <= memwritee;
      writeregm <= writerege;
      regwritew <= regwritem;
      memtoregw <= memtoregm;
      writeregw <= writeregm;
    end
  end

  // A jump's rt field is target bits, not a source register, so it never load-stalls
  assign lwstall = memtorege && !jumpd && (writerege != '0) &&
                   ((writerege == bus.rsd) || (writerege == bus.rtd));

  assign branchstall = branchd &&
    ((regwritee && (writerege != '0) &&
      ((writerege == bus.rsd) || (writerege == bus.rtd))) ||
     (memtoregm && (writeregm != '0) &&
      ((writeregm == bus.rsd) || (writeregm == bus.rtd))));

  assign stall = lwstall || branchstall;
  assign pcsrc = branchd && bus.eqd && !branchstall;
  assign jsel  = jumpd && !stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       stallcnt <= '0;
    else if (stall && ~&stallcnt)    stallcnt <= stallcnt + 1'b1;
  end

  pipe_fwd_unit #(.REGW(REGW)) u_fwd (
    .rsd       (bus.rsd),
    .rtd       (bus.rtd),
    .rse       (rse),
    .rte       (rte),
    .writeregm (writeregm),
    .writeregw (writeregw),
    .regwritem (regwritem),
    .regwritew (regwritew),
    .forwardae (bus.forwardae),
    .forwardbe (bus.forwardbe),
    .forwardad (bus.forwardad),
    .forwardbd (bus.forwardbd)
  );

  assign bus.stallf    = stall;
  assign bus.stalld    = stall;
  assign bus.flushe    = stall;
  assign bus.pcsrcd    = pcsrc;
  assign bus.jumpsel   = jsel;
  assign bus.flushd    = pcsrc || jsel;
  assign bus.regwritee = regwritee;
  assign bus.memtorege = memtorege;
  assign bus.memwritee = memwritee;
  assign bus.alusrce   = alusrce;
  assign bus.regdste   = regdste;
  assign bus.aluope    = aluope;
  assign bus.writerege = writerege;
  assign bus.regwritem = regwritem;
  assign bus.memtoregm = memtoregm;
  assign bus.memwritem = memwritem;
  assign bus.writeregm = writeregm;
  assign bus.regwritew = regwritew;
  assign bus.memtoregw = memtoregw;
  assign bus.writeregw = writeregw;
  assign bus.stallcnt  = stallcnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding chains, load-use and
// branch stalls, jumps, $0 handling, mid-stream reset and counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int REGW   = 5;
  localparam int ALUOPW = 4;
  localparam int CNTW   = 8;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REGW(REGW), .ALUOPW(ALUOPW), .CNTW(CNTW)) bus ();

  pipe_hazard_ctrl #(.REGW(REGW), .ALUOPW(ALUOPW), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // {regwrite,memtoreg,memwrite,aluop,alusrc,regdst,branch,jump}
  localparam logic [10:0] C_NOP  = 11'b0_0_0_0000_0_0_0_0;
  localparam logic [10:0] C_ADD  = 11'b1_0_0_0010_0_1_0_0;
  localparam logic [10:0] C_SUB  = 11'b1_0_0_0110_0_1_0_0;
  localparam logic [10:0] C_LW   = 11'b1_1_0_0010_1_0_0_0;
  localparam logic [10:0] C_BEQ  = 11'b0_0_0_0110_0_0_1_0;
  localparam logic [10:0] C_ADDI = 11'b1_0_0_0010_1_0_0_0;
  localparam logic [10:0] C_J    = 11'b0_0_0_0000_0_0_0_1;

  task automatic applyStimulus(input logic [10:0] ctrl, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic eq);
    bus.ctrld = ctrl;
    bus.rsd   = rs;
    bus.rtd   = rt;
    bus.rdd   = rd;
    bus.eqd   = eq;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(C_NOP, 0, 0, 0, 0);
    repeat (2) tick();
    checkOutput("rst_regwritee", bus.regwritee, 0);
    checkOutput("rst_writeregm", bus.writeregm, 0);
    checkOutput("rst_regwritew", bus.regwritew, 0);
    checkOutput("rst_stallcnt", bus.stallcnt, 0);
    checkOutput("rst_forwardae", bus.forwardae, 2'b00);
    rstn = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5 back to back
    applyStimulus(C_ADD, 1, 2, 3, 0);
    checkOutput("alu_nostall", bus.stalld, 0);
    tick();
    applyStimulus(C_SUB, 3, 5, 4, 0);
    checkOutput("alu_regwritee", bus.regwritee, 1);
    checkOutput("alu_writerege", bus.writerege, 3);
    checkOutput("alu_aluope", bus.aluope, 4'b0010);
    tick();
    applyStimulus(C_NOP, 0, 0, 0, 0);
    checkOutput("alu_fwdae_mem", bus.forwardae, 2'b10);
    checkOutput("alu_fwdbe_rf", bus.forwardbe, 2'b00);
    checkOutput("alu_writeregm", bus.writeregm, 3);
    tick();

    // same pair with a nop between them
    applyStimulus(C_ADD, 1, 2, 3, 0);
    tick();
    applyStimulus(C_NOP, 0, 0, 0, 0);
    tick();
    applyStimulus(C_SUB, 3, 5, 4, 0);
    tick();
    applyStimulus(C_NOP, 0, 0, 0, 0);
    checkOutput("nop_fwdae_wb", bus.forwardae, 2'b01);
    checkOutput("nop_writeregw", bus.writeregw, 3);
    tick();

    // lw $2,0($1) ; add $4,$2,$2
    applyStimulus(C_LW, 1, 2, 0, 0);
    tick();
    applyStimulus(C_ADD, 2, 2, 4, 0);
    checkOutput("lu_stallf", bus.stallf, 1);
    checkOutput("lu_stalld", bus.stalld, 1);
    checkOutput("lu_flushe", bus.flushe, 1);
    checkOutput("lu_writerege", bus.writerege, 2);
    tick();
    checkOutput("lu_released", bus.stalld, 0);
    checkOutput("lu_bubble_e", bus.regwritee, 0);
    checkOutput("lu_memtoregm", bus.memtoregm, 1);
    checkOutput("lu_stallcnt", bus.stallcnt, 1);
    tick();
    applyStimulus(C_NOP, 0, 0, 0, 0);
    checkOutput("lu_fwdae", bus.forwardae, 2'b01);
    checkOutput("lu_fwdbe", bus.forwardbe, 2'b01);
    checkOutput("lu_memtoregw", bus.memtoregw, 1);
    tick();

    // lw $2 ; beq $2,$0 : two stall cycles
    applyStimulus(C_LW, 1, 2, 0, 0);
    tick();
    applyStimulus(C_BEQ, 2, 0, 0, 1);
    checkOutput("lb_stall1", bus.stalld, 1);
    checkOutput("lb_pcsrc1", bus.pcsrcd, 0);
    checkOutput("lb_flushd1", bus.flushd, 0);
    tick();
    checkOutput("lb_stall2", bus.stalld, 1);
    checkOutput("lb_pcsrc2", bus.pcsrcd, 0);
    tick();
    checkOutput("lb_released", bus.stalld, 0);
    checkOutput("lb_fwdad", bus.forwardad, 0);
    checkOutput("lb_pcsrc3", bus.pcsrcd, 1);
    checkOutput("lb_flushd3", bus.flushd, 1);
    checkOutput("lb_stallcnt", bus.stallcnt, 3);
    applyStimulus(C_BEQ, 2, 0, 0, 0);
    checkOutput("lb_nottaken", bus.pcsrcd, 0);
    checkOutput("lb_noflush", bus.flushd, 0);
    applyStimulus(C_NOP, 0, 0, 0, 0);
    tick();

    // add $3 ; beq $3,$4 : one stall then forward from M
    applyStimulus(C_ADD, 1, 2, 3, 0);
    tick();
    applyStimulus(C_BEQ, 3, 4, 0, 1);
    checkOutput("ab_stall", bus.stalld, 1);
    tick();
    checkOutput("ab_released", bus.stalld, 0);
    checkOutput("ab_fwdad", bus.forwardad, 1);
    checkOutput("ab_fwdbd", bus.forwardbd, 0);
    checkOutput("ab_pcsrc", bus.pcsrcd, 1);
    applyStimulus(C_NOP, 0, 0, 0, 0);
    tick();

    // j whose target bits alias the load destination
    applyStimulus(C_LW, 1, 2, 0, 0);
    tick();
    applyStimulus(C_J, 0, 2, 0, 0);
    checkOutput("j_nostall", bus.stalld, 0);
    checkOutput("j_jumpsel", bus.jumpsel, 1);
    checkOutput("j_flushd", bus.flushd, 1);
    tick();
    applyStimulus(C_NOP, 0, 0, 0, 0);
    checkOutput("j_jumpsel_off", bus.jumpsel, 0);
    checkOutput("j_flushd_off", bus.flushd, 0);
    checkOutput("j_stallcnt", bus.stallcnt, 4);
    tick();

    // addi $0,$0,5 ; add $1,$0,$0
    applyStimulus(C_ADDI, 0, 0, 0, 0);
    tick();
    applyStimulus(C_ADD, 0, 0, 1, 0);
    checkOutput("z_nostall", bus.stalld, 0);
    tick();
    applyStimulus(C_BEQ, 0, 0, 0, 1);
    checkOutput("z_fwdae", bus.forwardae, 2'b00);
    checkOutput("z_fwdbe", bus.forwardbe, 2'b00);
    checkOutput("z_fwdad", bus.forwardad, 0);
    checkOutput("z_beqnostall", bus.stalld, 0);
    applyStimulus(C_LW, 1, 0, 0, 0);
    tick();
    applyStimulus(C_ADD, 0, 0, 5, 0);
    checkOutput("z_lwnostall", bus.stalld, 0);
    tick();

    // reset with a load-use pending
    applyStimulus(C_ADD, 1, 2, 3, 0);
    tick();
    applyStimulus(C_LW, 1, 2, 0, 0);
    tick();
    applyStimulus(C_ADD, 2, 2, 4, 0);
    checkOutput("mr_pre_stall", bus.stalld, 1);
    rstn = 1'b0;
    #1;
    checkOutput("mr_regwritee", bus.regwritee, 0);
    checkOutput("mr_memtorege", bus.memtorege, 0);
    checkOutput("mr_writerege", bus.writerege, 0);
    checkOutput("mr_regwritem", bus.regwritem, 0);
    checkOutput("mr_writeregm", bus.writeregm, 0);
    checkOutput("mr_stallcnt", bus.stallcnt, 0);
    checkOutput("mr_stalld", bus.stalld, 0);
    checkOutput("mr_fwdae", bus.forwardae, 2'b00);
    tick();
    checkOutput("mr_regwritew", bus.regwritew, 0);
    checkOutput("mr_held_cnt", bus.stallcnt, 0);
    applyStimulus(C_NOP, 0, 0, 0, 0);
    rstn = 1'b1;

    // one load-use stall per pair until the counter saturates
    for (int i = 0; i < 250; i++) begin
      applyStimulus(C_LW, 1, 2, 0, 0);
      tick();
      applyStimulus(C_ADD, 2, 2, 4, 0);
      tick();
    end
    checkOutput("sat_250", bus.stallcnt, 250);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(C_LW, 1, 2, 0, 0);
      tick();
      applyStimulus(C_ADD, 2, 2, 4, 0);
      tick();
    end
    checkOutput("sat_255", bus.stallcnt, 255);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(C_LW, 1, 2, 0, 0);
      tick();
      applyStimulus(C_ADD, 2, 2, 4, 0);
      tick();
    end
    checkOutput("sat_hold", bus.stallcnt, 255);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
